// File: rtl/pulse_cfg_rx.sv
// pulse_cfg_rx
//   UART (8N1) configuration receiver for the pulse generator. Bytes are
//   deserialised, a fixed 23-byte frame (sync, 21 payload bytes, XOR checksum)
//   is parsed into shadow registers, and on a good checksum every timing output
//   is loaded in the same cycle while cfg_done is held high for DONE_CYCLES.
//
//   Optional feature: define PCFG_TIMEOUT_EN to abort a frame whose bytes stop
//   arriving for TIMEOUT_CLKS cycles (frame_err pulse, partial frame dropped).
//
// Ports
//   clk_pll   in   PLL clock
//   reset     in   synchronous, active-low
//   uart_rx   in   asynchronous serial input, idles high
//   pu        out  pump pulse enable
//   per       out  period, units of 2^16 cycles
//   p1wid     out  first pulse width
//   del       out  pulse delay
//   p2wid     out  second pulse width
//   nut_w     out  nutation pulse width
//   nut_d     out  nutation pulse delay
//   cp        out  mode: 0=CW, 1=Hahn, >1=CPMG pi-pulse count
//   p_bl      out  block lead time
//   p_bl_off  out  block window width
//   bl        out  blocking enable
//   cfg_done  out  high DONE_CYCLES cycles after each commit
//   frame_err out  one-cycle pulse on a rejected frame
module pulse_cfg_rx #(
  parameter int          CLKS_PER_BIT = 1745,
  parameter int          DONE_CYCLES  = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [19:0] TIMEOUT_CLKS = 20'd174500
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        pu,
  output logic [7:0]  per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [31:0] nut_w,
  output logic [31:0] nut_d,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        cfg_done,
  output logic        frame_err
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int DONE_W = $clog2(DONE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DONE_W-1:0] DONE_LOAD = DONE_W'(DONE_CYCLES - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK, P_COMMIT} parse_state_t;

  bit_state_t   bit_state, bit_next;
  parse_state_t p_state, p_next;

  logic             rx_meta, rx_sync, rx_prev;
  logic             rx_fall;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             data_sample, byte_ok, line_err;
  logic             byte_valid, byte_err;

  logic [7:0]        shadow [21];
  logic [4:0]        idx;
  logic [7:0]        xor_acc;
  logic              err_set;
  logic              timeout_hit;
  logic [DONE_W-1:0] done_cnt;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  always_ff @(posedge clk_pll) begin
    if (!reset) bit_state <= B_IDLE;
    else        bit_state <= bit_next;
  end

  always_comb begin
    bit_next    = bit_state;
    data_sample = 1'b0;
    byte_ok     = 1'b0;
    line_err    = 1'b0;
    case (bit_state)
      B_IDLE:  if (rx_fall) bit_next = B_START;
      // Mid-start re-check rejects glitches shorter than half a bit.
      B_START: if (bit_cnt == HALF_LAST) bit_next = rx_sync ? B_IDLE : B_DATA;
      B_DATA: begin
        if (bit_cnt == BIT_LAST) begin
          data_sample = 1'b1;
          if (bit_idx == 3'd7) bit_next = B_STOP;
        end
      end
      B_STOP: begin
        if (bit_cnt == BIT_LAST) begin
          bit_next = B_IDLE;
          byte_ok  = rx_sync;
          line_err = ~rx_sync;
        end
      end
      default: bit_next = B_IDLE;
    endcase
  end

  // Counter restarts on every state change, so DATA samples land one full bit
  // after the mid-start point, i.e. in the middle of each data bit.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      bit_cnt    <= '0;
      bit_idx    <= 3'd0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= byte_ok;
      byte_err   <= line_err;
      if (bit_next != bit_state || bit_state == B_IDLE || bit_cnt == BIT_LAST)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
      if (bit_state == B_START) bit_idx <= 3'd0;
      if (data_sample) begin
        rx_byte <= {rx_sync, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

`ifdef PCFG_TIMEOUT_EN
  logic [19:0] to_cnt;

  always_ff @(posedge clk_pll) begin
    if (!reset || byte_valid || p_state == P_HUNT) to_cnt <= 20'd0;
    else if (!timeout_hit)                          to_cnt <= to_cnt + 20'd1;
  end

  assign timeout_hit = (to_cnt == TIMEOUT_CLKS);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_pll) begin
    if (!reset) p_state <= P_HUNT;
    else        p_state <= p_next;
  end

  always_comb begin
    p_next  = p_state;
    err_set = 1'b0;
    case (p_state)
      P_HUNT:    if (byte_valid && rx_byte == SYNC_BYTE) p_next = P_PAYLOAD;
      P_PAYLOAD: if (byte_valid && idx == 5'd20) p_next = P_CHECK;
      P_CHECK: begin
        if (byte_valid) begin
          if (rx_byte == xor_acc) begin
            p_next = P_COMMIT;
          end else begin
            err_set = 1'b1;
            p_next  = P_HUNT;
          end
        end
      end
      P_COMMIT:  p_next = P_HUNT;
      default:   p_next = P_HUNT;
    endcase
    // COMMIT is excluded so a rejection can never coincide with a load.
    if ((p_state == P_PAYLOAD || p_state == P_CHECK) && (byte_err || timeout_hit)) begin
      err_set = 1'b1;
      p_next  = P_HUNT;
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      idx       <= 5'd0;
      xor_acc   <= 8'h00;
      for (int i = 0; i < 21; i++) shadow[i] <= 8'h00;
      pu        <= 1'b1;
      per       <= 8'd1;
      p1wid     <= 16'd30;
      del       <= 16'd200;
      p2wid     <= 16'd30;
      nut_w     <= 32'd50;
      nut_d     <= 32'd300;
      cp        <= 8'd3;
      p_bl      <= 8'd50;
      p_bl_off  <= 16'd100;
      bl        <= 1'b1;
      cfg_done  <= 1'b0;
      done_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_set;
      if (p_state == P_HUNT && byte_valid && rx_byte == SYNC_BYTE) begin
        idx     <= 5'd0;
        xor_acc <= 8'h00;
      end
      if (p_state == P_PAYLOAD && byte_valid) begin
        shadow[idx] <= rx_byte;
        xor_acc     <= xor_acc ^ rx_byte;
        idx         <= idx + 5'd1;
      end
      if (p_state == P_COMMIT) begin
        pu        <= shadow[0][0];
        per       <= shadow[1];
        p1wid     <= {shadow[2], shadow[3]};
        del       <= {shadow[4], shadow[5]};
        p2wid     <= {shadow[6], shadow[7]};
        nut_w     <= {shadow[8], shadow[9], shadow[10], shadow[11]};
        nut_d     <= {shadow[12], shadow[13], shadow[14], shadow[15]};
        cp        <= shadow[16];
        p_bl      <= shadow[17];
        p_bl_off  <= {shadow[18], shadow[19]};
        bl        <= shadow[20][0];
        // Registered flag, not a decode of done_cnt, so the cross-domain
        // strobe is glitch-free. A new commit restarts the count.
        cfg_done  <= 1'b1;
        done_cnt  <= DONE_LOAD;
      end else if (done_cnt != '0) begin
        done_cnt  <= done_cnt - 1'b1;
      end else begin
        cfg_done  <= 1'b0;
      end
    end
  end

  // Only bit 0 of the pu and bl bytes carries information.
  logic unused_shadow_bits;
  assign unused_shadow_bits = &{1'b0, shadow[0][7:1], shadow[20][7:1]};

endmodule

// File: tb/tb_pulse_cfg_rx.sv
module tb_pulse_cfg_rx;

  localparam int CPB = 16;

  logic        clk_pll = 1'b0;
  logic        reset   = 1'b0;
  logic        uart_rx = 1'b1;
  logic        pu, bl, cfg_done, frame_err;
  logic [7:0]  per, cp, p_bl;
  logic [15:0] p1wid, del, p2wid, p_bl_off;
  logic [31:0] nut_w, nut_d;

  pulse_cfg_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_pll(clk_pll), .reset(reset), .uart_rx(uart_rx),
    .pu(pu), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
    .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off),
    .bl(bl), .cfg_done(cfg_done), .frame_err(frame_err)
  );

  always #5 clk_pll = ~clk_pll;

  int applied     = 0;
  int miscompares = 0;

  // Output activity seen between checkpoints
  int   done_hi   = 0;
  int   done_rise = 0;
  int   err_hi    = 0;
  logic done_prev = 1'b0;

  always @(negedge clk_pll) begin
    if (cfg_done) done_hi++;
    if (cfg_done && !done_prev) done_rise++;
    done_prev = cfg_done;
    if (frame_err) err_hi++;
  end

  // Expected field values and the payload built from them
  logic        exp_pu, exp_bl;
  logic [7:0]  exp_per, exp_cp, exp_p_bl;
  logic [15:0] exp_p1wid, exp_del, exp_p2wid, exp_p_bl_off;
  logic [31:0] exp_nut_w, exp_nut_d;
  logic [7:0]  pay [21];
  logic [7:0]  chk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic setDefaults();
    exp_pu = 1'b1;        exp_per = 8'd1;      exp_p1wid = 16'd30;  exp_del = 16'd200;
    exp_p2wid = 16'd30;   exp_nut_w = 32'd50;  exp_nut_d = 32'd300; exp_cp = 8'd3;
    exp_p_bl = 8'd50;     exp_p_bl_off = 16'd100; exp_bl = 1'b1;
  endtask

  task automatic setTest2();
    setDefaults();
    exp_p1wid = 16'h0040;
    exp_del   = 16'h0190;
    exp_nut_d = 32'h00012345;
    exp_cp    = 8'd1;
  endtask

  task automatic packFields();
    pay[0]  = {7'd0, exp_pu};
    pay[1]  = exp_per;
    pay[2]  = exp_p1wid[15:8];    pay[3]  = exp_p1wid[7:0];
    pay[4]  = exp_del[15:8];      pay[5]  = exp_del[7:0];
    pay[6]  = exp_p2wid[15:8];    pay[7]  = exp_p2wid[7:0];
    pay[8]  = exp_nut_w[31:24];   pay[9]  = exp_nut_w[23:16];
    pay[10] = exp_nut_w[15:8];    pay[11] = exp_nut_w[7:0];
    pay[12] = exp_nut_d[31:24];   pay[13] = exp_nut_d[23:16];
    pay[14] = exp_nut_d[15:8];    pay[15] = exp_nut_d[7:0];
    pay[16] = exp_cp;
    pay[17] = exp_p_bl;
    pay[18] = exp_p_bl_off[15:8]; pay[19] = exp_p_bl_off[7:0];
    pay[20] = {7'd0, exp_bl};
    chk = 8'h00;
    for (int i = 0; i < 21; i++) chk = chk ^ pay[i];
  endtask

  task automatic checkAll(input string phase);
    checkOutput({phase, ".pu"},       32'(pu),       32'(exp_pu));
    checkOutput({phase, ".per"},      32'(per),      32'(exp_per));
    checkOutput({phase, ".p1wid"},    32'(p1wid),    32'(exp_p1wid));
    checkOutput({phase, ".del"},      32'(del),      32'(exp_del));
    checkOutput({phase, ".p2wid"},    32'(p2wid),    32'(exp_p2wid));
    checkOutput({phase, ".nut_w"},    nut_w,         exp_nut_w);
    checkOutput({phase, ".nut_d"},    nut_d,         exp_nut_d);
    checkOutput({phase, ".cp"},       32'(cp),       32'(exp_cp));
    checkOutput({phase, ".p_bl"},     32'(p_bl),     32'(exp_p_bl));
    checkOutput({phase, ".p_bl_off"}, 32'(p_bl_off), 32'(exp_p_bl_off));
    checkOutput({phase, ".bl"},       32'(bl),       32'(exp_bl));
  endtask

  task automatic clearActivity();
    done_hi = 0;
    done_rise = 0;
    err_hi = 0;
  endtask

  // One 8N1 byte, 10 bit times; stop_bit=0 forces a framing error.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk_pll);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk_pll);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk_pll);
    uart_rx = 1'b1;
  endtask

  task automatic sendPayload(input int first, input int last);
    for (int i = first; i <= last; i++) applyStimulus(pay[i], 1'b1);
  endtask

  task automatic sendFrame(input logic [7:0] chk_mask);
    applyStimulus(8'hA5, 1'b1);
    sendPayload(0, 20);
    applyStimulus(chk ^ chk_mask, 1'b1);
    repeat (40) @(negedge clk_pll);
  endtask

  initial begin
    // 1: reset defaults
    reset = 1'b0;
    repeat (2) @(negedge clk_pll);
    reset = 1'b1;
    @(negedge clk_pll);
    setDefaults();
    checkAll("reset");
    checkOutput("reset.cfg_done",  32'(cfg_done),  32'd0);
    checkOutput("reset.frame_err", 32'(frame_err), 32'd0);
    repeat (5) @(negedge clk_pll);
    clearActivity();

    // 2: valid frame
    setTest2();
    packFields();
    checkOutput("t2.chk_model", 32'(chk), 32'hCC);
    sendFrame(8'h00);
    checkAll("t2");
    checkOutput("t2.done_cycles", 32'(done_hi),   32'd8);
    checkOutput("t2.done_rises",  32'(done_rise), 32'd1);
    checkOutput("t2.frame_err",   32'(err_hi),    32'd0);
    clearActivity();

    // 3: bad checksum
    sendFrame(8'h01);
    checkAll("t3");
    checkOutput("t3.frame_err_cycles", 32'(err_hi),    32'd1);
    checkOutput("t3.done_rises",       32'(done_rise), 32'd0);
    clearActivity();

    // 4: framing error on payload byte 5, then a good frame
    applyStimulus(8'hA5, 1'b1);
    sendPayload(0, 3);
    applyStimulus(pay[4], 1'b0);
    repeat (3 * CPB) @(negedge clk_pll);
    checkAll("t4a");
    checkOutput("t4a.frame_err_cycles", 32'(err_hi),    32'd1);
    checkOutput("t4a.done_rises",       32'(done_rise), 32'd0);
    clearActivity();
    exp_p2wid = 16'h1234;
    exp_cp    = 8'd5;
    packFields();
    sendFrame(8'h00);
    checkAll("t4b");
    checkOutput("t4b.done_rises", 32'(done_rise), 32'd1);
    checkOutput("t4b.frame_err",  32'(err_hi),    32'd0);
    clearActivity();

    // 5: junk bytes, then a frame carrying the sync value as data
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    exp_p_bl  = 8'hA5;
    exp_nut_w = 32'hA5000001;
    packFields();
    sendFrame(8'h00);
    checkAll("t5");
    checkOutput("t5.done_rises", 32'(done_rise), 32'd1);
    checkOutput("t5.frame_err",  32'(err_hi),    32'd0);
    clearActivity();

    // 6: reset in the middle of a payload
    setTest2();
    packFields();
    applyStimulus(8'hA5, 1'b1);
    sendPayload(0, 9);
    reset = 1'b0;
    repeat (2) @(negedge clk_pll);
    reset = 1'b1;
    @(negedge clk_pll);
    setDefaults();
    checkAll("t6a");
    checkOutput("t6a.cfg_done", 32'(cfg_done), 32'd0);
    sendPayload(10, 20);
    applyStimulus(chk, 1'b1);
    repeat (40) @(negedge clk_pll);
    checkAll("t6b");
    checkOutput("t6b.done_rises", 32'(done_rise), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
